interrupt_sequencer: RTL and testbench

//  Controls hardware entry into the interrupt handler for the 5-stage pipeline.

---
 rtl/interrupt_sequencer_pkg.sv | 23 ++
 rtl/interrupt_sequencer_if.sv | 42 ++++
 rtl/interrupt_sequencer_edge_latch.sv | 26 ++
 rtl/interrupt_sequencer.sv | 117 +++++++++++
 tb/tb_interrupt_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared CPU definitions used by the interrupt entry sequencer: state encoding,
// default widths and the interrupt vector.
package cpu_pkg;

  localparam int          DATA_W       = 16;
  localparam int          CCR_W        = 4;
  localparam logic [31:0] INT_VEC_ADDR = 32'h1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    PUSH_HI  = 3'd2,
    PUSH_LO  = 3'd3,
    PUSH_CCR = 3'd4,
    VECTOR   = 3'd5,
    HANDLER  = 3'd6
  } int_state_t;

  function automatic logic is_push_state(input logic [2:0] s);
    return (s == PUSH_HI) || (s == PUSH_LO) || (s == PUSH_CCR);
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pipeline-facing signal bundle of the interrupt sequencer. The master modport is
// the sequencer itself; the slave modport is the core (IF stage, hazard unit, MEM).
interface interrupt_sequencer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 16
);

  logic                      interupt;
  logic                      pipe_hold;
  logic                      branch_busy;
  logic [PC_W-1:0]           if_pc;
  logic [cpu_pkg::CCR_W-1:0] ccr;
  logic                      mem_grant;
  logic                      rti_retire;

  logic                      fetch_stall;
  logic                      flush_if_id;
  logic                      mem_req;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      sp_dec;
  logic                      pc_load;
  logic [PC_W-1:0]           pc_load_val;
  logic                      int_active;
  logic                      int_pending;

  // Memory handshake: mem_req (with mem_we and mem_wdata stable) stays high until
  // mem_grant; the word is written in the cycle both are high, and only then does
  // the requester move on.
  modport master (
    input  interupt, pipe_hold, branch_busy, if_pc, ccr, mem_grant, rti_retire,
    output fetch_stall, flush_if_id, mem_req, mem_we, mem_wdata, sp_dec,
           pc_load, pc_load_val, int_active, int_pending
  );

  modport slave (
    output interupt, pipe_hold, branch_busy, if_pc, ccr, mem_grant, rti_retire,
    input  fetch_stall, flush_if_id, mem_req, mem_we, mem_wdata, sp_dec,
           pc_load, pc_load_val, int_active, int_pending
  );

endinterface

// File: rtl/interrupt_sequencer_edge_latch.sv
// Rising-edge detector with a single-depth pending flag; a set wins over a
// same-cycle clear so an edge arriving at acceptance is never lost.
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic clear,
  output logic pending
);

  logic level_q;
  logic rise;

  assign rise = level & ~level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      pending <= 1'b0;
    end else begin
      level_q <= level;
      pending <= rise | (pending & ~clear);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Hardware interrupt entry: waits for a safe point, squashes IF, drains the pipe,
// pushes {PC hi, PC lo, CCR} through the data port, then redirects fetch.
module interrupt_sequencer #(
  parameter int          PC_W         = 32,
  parameter int          DATA_W       = cpu_pkg::DATA_W,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] INT_VEC_ADDR = cpu_pkg::INT_VEC_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  interrupt_sequencer_if.master bus,
  output logic [2:0]            state_dbg
);

  import cpu_pkg::*;

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_DRAIN    = DRAIN;
  localparam logic [2:0] S_PUSH_HI  = PUSH_HI;
  localparam logic [2:0] S_PUSH_LO  = PUSH_LO;
  localparam logic [2:0] S_PUSH_CCR = PUSH_CCR;
  localparam logic [2:0] S_VECTOR   = VECTOR;
  localparam logic [2:0] S_HANDLER  = HANDLER;

  localparam int              CNT_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [CNT_W-1:0]  drain_cnt;
  logic [PC_W-1:0]   resume_pc;
  logic              pending;
  logic              accept;
  logic              in_push;
  logic [DATA_W-1:0] hi_word;
  logic [DATA_W-1:0] lo_word;
  logic [DATA_W-1:0] ccr_word;

  int_edge_latch u_edge_latch (
    .clk     (clk),
    .reset   (reset),
    .level   (bus.interupt),
    .clear   (accept),
    .pending (pending)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending && !bus.pipe_hold && !bus.branch_busy) begin
          accept     = 1'b1;
          next_state = S_DRAIN;
        end
      end
      S_DRAIN:    if (drain_cnt == DRAIN_LAST) next_state = S_PUSH_HI;
      S_PUSH_HI:  if (bus.mem_grant) next_state = S_PUSH_LO;
      S_PUSH_LO:  if (bus.mem_grant) next_state = S_PUSH_CCR;
      S_PUSH_CCR: if (bus.mem_grant) next_state = S_VECTOR;
      S_VECTOR:   next_state = S_HANDLER;
      S_HANDLER:  if (bus.rti_retire) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      resume_pc <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        drain_cnt <= '0;
        resume_pc <= bus.if_pc;
      end else if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

  // Stack words are zero-extended into the data-memory width.
  always_comb begin
    hi_word                  = '0;
    hi_word[PC_W-17:0]       = resume_pc[PC_W-1:16];
    lo_word                  = '0;
    lo_word[15:0]            = resume_pc[15:0];
    ccr_word                 = '0;
    ccr_word[CCR_W-1:0]      = bus.ccr;
  end

  assign in_push = is_push_state(state);

  always_comb begin
    bus.mem_wdata = '0;
    case (state)
      S_PUSH_HI:  bus.mem_wdata = hi_word;
      S_PUSH_LO:  bus.mem_wdata = lo_word;
      S_PUSH_CCR: bus.mem_wdata = ccr_word;
      default:    bus.mem_wdata = '0;
    endcase
  end

  assign bus.fetch_stall = (state == S_DRAIN) || in_push;
  assign bus.flush_if_id = accept;
  assign bus.mem_req     = in_push;
  assign bus.mem_we      = in_push;
  assign bus.sp_dec      = in_push && bus.mem_grant;
  assign bus.pc_load     = (state == S_VECTOR);
  // Constant vector keeps the redirect target glitch-free in every state.
  assign bus.pc_load_val = INT_VEC_ADDR[PC_W-1:0];
  assign bus.int_active  = (state != S_IDLE);
  assign bus.int_pending = pending;
  assign state_dbg       = state;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: scoreboard of expected stack words and
// redirect cycles, checked by a monitor on every granted push and pc_load.
module tb_interrupt_sequencer;
  import cpu_pkg::*;

  localparam int PC_W = 32;
  localparam int DW   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  interrupt_sequencer_if #(.PC_W(PC_W), .DATA_W(DW)) bus ();

  interrupt_sequencer #(
    .PC_W(PC_W), .DATA_W(DW), .DRAIN_CYCLES(3), .INT_VEC_ADDR(32'h1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_bad  = 0;
  int sp_cnt = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_pc_cyc_q[$];
  logic [DW-1:0] w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not as expected (cycle %0d)", name, cyc);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_grant) begin
        sp_cnt++;
        check("sp_dec_on_grant", 32'(bus.sp_dec), 32'd1);
        check("mem_we", 32'(bus.mem_we), 32'd1);
        if (exp_q.size() == 0) fail("unexpected_push");
        else begin
          w = exp_q.pop_front();
          check("push_wdata", 32'(bus.mem_wdata), 32'(w));
        end
      end else begin
        check("sp_dec_no_grant", 32'(bus.sp_dec), 32'd0);
      end
      if (bus.pc_load) begin
        check("pc_load_val", bus.pc_load_val, 32'h1);
        if (exp_pc_cyc_q.size() == 0) fail("unexpected_pc_load");
        else check("pc_load_cycle", 32'(cyc), 32'(exp_pc_cyc_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int budget, output int acc);
    acc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.flush_if_id) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail("accept_timeout");
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (state_dbg == s) return;
    end
    fail("wait_state_timeout");
  endtask

  task automatic finish_service();
    wait_state(HANDLER, 40);
    bus.rti_retire = 1'b1;
    step();
    bus.rti_retire = 1'b0;
    @(negedge clk);
    check("rti_to_idle", 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_fetch_stall"}, 32'(bus.fetch_stall), 32'd0);
    check({name, "_flush"},       32'(bus.flush_if_id), 32'd0);
    check({name, "_mem_req"},     32'(bus.mem_req), 32'd0);
    check({name, "_mem_we"},      32'(bus.mem_we), 32'd0);
    check({name, "_wdata"},       32'(bus.mem_wdata), 32'd0);
    check({name, "_sp_dec"},      32'(bus.sp_dec), 32'd0);
    check({name, "_pc_load"},     32'(bus.pc_load), 32'd0);
    check({name, "_active"},      32'(bus.int_active), 32'd0);
    check({name, "_pending"},     32'(bus.int_pending), 32'd0);
    check({name, "_state"},       32'(state_dbg), 32'(IDLE));
    check({name, "_vec"},         bus.pc_load_val, 32'h1);
  endtask

  int a;
  int a2;
  int r;
  int s0;

  initial begin
    reset           = 1'b1;
    bus.interupt    = 1'b0;
    bus.pipe_hold   = 1'b0;
    bus.branch_busy = 1'b0;
    bus.if_pc       = '0;
    bus.ccr         = '0;
    bus.mem_grant   = 1'b1;
    bus.rti_retire  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    step();

    // reset in the middle of PUSH_LO, with a second edge pending
    bus.if_pc = 32'h0000_0012;
    bus.ccr   = 4'b1010;
    exp_q.push_back(16'h0000);
    bus.interupt = 1'b1;
    step();
    bus.interupt = 1'b0;
    wait_accept(5, a);
    step();
    bus.interupt = 1'b1;
    step();
    bus.interupt = 1'b0;
    wait_state(PUSH_LO, 10);
    bus.mem_grant = 1'b0;
    check("pending_before_reset", 32'(bus.int_pending), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("mid_push_reset");
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.mem_grant = 1'b1;
    step();

    // basic entry: level held 3 cycles gives one service; rti during DRAIN ignored
    bus.if_pc = 32'h0000_0012;
    bus.ccr   = 4'b1010;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0012);
    exp_q.push_back(16'h000A);
    s0 = sp_cnt;
    bus.interupt = 1'b1;
    step();
    fork
      begin
        repeat (3) step();
        bus.interupt = 1'b0;
      end
      begin
        wait_accept(3, a);
        exp_pc_cyc_q.push_back(a + 7);
      end
    join
    check("basic_pending_cleared", 32'(bus.int_pending), 32'd0);
    check("basic_active", 32'(bus.int_active), 32'd1);
    check("basic_stall", 32'(bus.fetch_stall), 32'd1);
    bus.rti_retire = 1'b1;
    step();
    bus.rti_retire = 1'b0;
    wait_state(HANDLER, 20);
    check("basic_sp_dec_count", 32'(sp_cnt - s0), 32'd3);
    check("basic_handler_no_stall", 32'(bus.fetch_stall), 32'd0);
    finish_service();
    repeat (3) step();
    check("basic_single_service", 32'(state_dbg), 32'(IDLE));

    // safe-point gating: two hold cycles, one branch cycle, then accept
    bus.ccr       = 4'b0101;
    bus.pipe_hold = 1'b1;
    bus.if_pc     = 32'h0000_0100;
    bus.interupt  = 1'b1;
    step();
    bus.interupt = 1'b0;
    bus.if_pc    = 32'h0000_0104;
    @(negedge clk);
    check("gate_hold1", 32'(bus.flush_if_id), 32'd0);
    step();
    bus.if_pc = 32'h0000_0108;
    @(negedge clk);
    check("gate_hold2", 32'(bus.flush_if_id), 32'd0);
    check("gate_pending", 32'(bus.int_pending), 32'd1);
    step();
    bus.pipe_hold   = 1'b0;
    bus.branch_busy = 1'b1;
    bus.if_pc       = 32'h0000_010C;
    @(negedge clk);
    check("gate_branch", 32'(bus.flush_if_id), 32'd0);
    step();
    bus.branch_busy = 1'b0;
    bus.if_pc       = 32'h0001_0034;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0034);
    exp_q.push_back(16'h0005);
    wait_accept(1, a);
    exp_pc_cyc_q.push_back(a + 7);
    step();
    bus.if_pc = 32'h0000_0200;
    finish_service();

    // grant backpressure: four ungranted cycles in PUSH_LO
    bus.ccr       = 4'b0011;
    bus.if_pc     = 32'h0000_0012;
    bus.mem_grant = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0012);
    exp_q.push_back(16'h0003);
    bus.interupt = 1'b1;
    step();
    bus.interupt = 1'b0;
    wait_accept(5, a);
    exp_pc_cyc_q.push_back(a + 11);
    wait_state(PUSH_HI, 10);
    bus.mem_grant = 1'b1;
    step();
    bus.mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_state", 32'(state_dbg), 32'(PUSH_LO));
      check("bp_wdata", 32'(bus.mem_wdata), 32'h0012);
      check("bp_stall", 32'(bus.fetch_stall), 32'd1);
      check("bp_req", 32'(bus.mem_req), 32'd1);
      step();
    end
    bus.mem_grant = 1'b1;
    finish_service();

    // nesting block: edge inside HANDLER waits for RTI, then re-accepts next cycle
    bus.ccr   = 4'b1111;
    bus.if_pc = 32'h0000_0456;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0456);
    exp_q.push_back(16'h000F);
    bus.interupt = 1'b1;
    step();
    bus.interupt = 1'b0;
    wait_accept(5, a);
    exp_pc_cyc_q.push_back(a + 7);
    wait_state(HANDLER, 20);
    bus.interupt = 1'b1;
    step();
    bus.interupt = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("nest_pending", 32'(bus.int_pending), 32'd1);
    check("nest_state", 32'(state_dbg), 32'(HANDLER));
    check("nest_no_flush", 32'(bus.flush_if_id), 32'd0);
    bus.if_pc = 32'h0000_0789;
    bus.ccr   = 4'b0110;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0789);
    exp_q.push_back(16'h0006);
    step();
    bus.rti_retire = 1'b1;
    r = cyc;
    step();
    bus.rti_retire = 1'b0;
    wait_accept(1, a2);
    check("nest_reaccept_cycle", 32'(a2), 32'(r + 1));
    exp_pc_cyc_q.push_back(a2 + 7);
    step();
    finish_service();

    // coalescing: two edges before acceptance give one frame
    bus.pipe_hold = 1'b1;
    bus.if_pc     = 32'h0000_0A0B;
    bus.ccr       = 4'b0001;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0A0B);
    exp_q.push_back(16'h0001);
    bus.interupt = 1'b1;
    step();
    bus.interupt = 1'b0;
    step();
    bus.interupt = 1'b1;
    step();
    bus.interupt = 1'b0;
    step();
    check("coal_pending", 32'(bus.int_pending), 32'd1);
    bus.pipe_hold = 1'b0;
    wait_accept(2, a);
    exp_pc_cyc_q.push_back(a + 7);
    step();
    check("coal_pending_cleared", 32'(bus.int_pending), 32'd0);
    finish_service();
    repeat (4) step();
    check("coal_idle", 32'(state_dbg), 32'(IDLE));
    check("coal_no_pending", 32'(bus.int_pending), 32'd0);

    // report
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_pc_q_drained", 32'(exp_pc_cyc_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
